// File: rtl/jk_sync_counter_pkg.sv
// jk_sync_counter_pkg: direction constants and J/K command encodings ({J,K}) shared by JK-based blocks.
package jk_sync_counter_pkg;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;
endpackage

// File: rtl/jk_counter_stage.sv
// jk_counter_stage: single JK storage bit with asynchronous active-low reset and true/complement outputs.
module jk_counter_stage
    import jk_sync_counter_pkg::*;
(
    input  logic clock_pos,
    input  logic reset_neg,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic q_n_o
);
    logic    q_q, q_d;
    jk_cmd_e cmd;
    always_comb begin
        cmd = jk_cmd_e'({j_i, k_i});
        q_d = (cmd == JK_SET)    ? 1'b1 :
              (cmd == JK_RESET)  ? 1'b0 :
              (cmd == JK_TOGGLE) ? ~q_q : q_q;
    end
    always_ff @(posedge clock_pos or negedge reset_neg) begin
        if (!reset_neg) q_q <= 1'b0;
        else            q_q <= q_d;
    end
    assign q_o   = q_q;
    assign q_n_o = ~q_q;
endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MODULUS up/down counter built from a chain of JK stages.
// Define JK_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module jk_sync_counter
    import jk_sync_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clock_pos,
    input  logic             reset_neg,
    input  logic             count_enable,
    input  logic             count_up,
    input  logic             load_enable,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_out,
    output logic [WIDTH-1:0] count_out_neg,
    output logic             terminal_count,
    output logic             wrap_pulse
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] j_d, k_d, load_val;
`ifndef JK_COUNTER_SATURATE_EN
    logic [WIDTH-1:0] wrap_val;
`endif
    logic    all1, all0;
    jk_cmd_e cmd;
    assign terminal_count = (count_up == DIR_UP) ? (count_out == MAX) : (count_out == '0);
    always_comb begin
        load_val = (32'(load_value) >= MODULUS) ? MAX : load_value;
`ifndef JK_COUNTER_SATURATE_EN
        wrap_val = (count_up == DIR_DOWN) ? MAX : '0;
`endif
        j_d  = '0;
        k_d  = '0;
        cmd  = JK_HOLD;
        all1 = 1'b1;
        all0 = 1'b1;
        // all1/all0 accumulate "every lower bit is 1/0" to form the toggle chain
        for (int i = 0; i < WIDTH; i++) begin
            cmd = load_enable ? (load_val[i] ? JK_SET : JK_RESET) :
                  !count_enable ? JK_HOLD :
`ifdef JK_COUNTER_SATURATE_EN
                  terminal_count ? JK_HOLD :
`else
                  terminal_count ? (wrap_val[i] ? JK_SET : JK_RESET) :
`endif
                  (((count_up == DIR_UP) ? all1 : all0) ? JK_TOGGLE : JK_HOLD);
            {j_d[i], k_d[i]} = cmd;
            all1 = all1 & count_out[i];
            all0 = all0 & ~count_out[i];
        end
    end
    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        jk_counter_stage u_stage (
            .clock_pos (clock_pos),
            .reset_neg (reset_neg),
            .j_i       (j_d[g]),
            .k_i       (k_d[g]),
            .q_o       (count_out[g]),
            .q_n_o     (count_out_neg[g])
        );
    end
`ifdef JK_COUNTER_SATURATE_EN
    assign wrap_pulse = 1'b0;
`else
    logic wrap_d, wrap_q;
    assign wrap_d = !load_enable && count_enable && terminal_count;
    always_ff @(posedge clock_pos or negedge reset_neg) begin
        if (!reset_neg) wrap_q <= 1'b0;
        else            wrap_q <= wrap_d;
    end
    assign wrap_pulse = wrap_q;
`endif
endmodule

// File: tb/tb_jk_sync_counter.sv
// tb_jk_sync_counter: scoreboard bench for jk_sync_counter (WIDTH=4, MODULUS=10).
// Saturation checks run when JK_COUNTER_SATURATE_EN is defined.
module tb_jk_sync_counter;
    localparam int W = 4;
    localparam int M = 10;

    typedef struct {
        logic [W-1:0] cnt;
        logic         wrap;
        logic         tc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_neg = 1'b1;
    logic         count_enable = 1'b0;
    logic         count_up = 1'b1;
    logic         load_enable = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] count_out, count_out_neg;
    logic         terminal_count, wrap_pulse;

    exp_t sb[$];
    exp_t e;
    int   m_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clock_pos      (clk),
        .reset_neg      (reset_neg),
        .count_enable   (count_enable),
        .count_up       (count_up),
        .load_enable    (load_enable),
        .load_value     (load_value),
        .count_out      (count_out),
        .count_out_neg  (count_out_neg),
        .terminal_count (terminal_count),
        .wrap_pulse     (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic up, input logic ld, input logic [W-1:0] lv);
        exp_t x;
        logic w;
        count_enable = en;
        count_up     = up;
        load_enable  = ld;
        load_value   = lv;
        w = 1'b0;
        if (ld) m_cnt = (int'(lv) >= M) ? M - 1 : int'(lv);
        else if (en && up) begin
`ifdef JK_COUNTER_SATURATE_EN
            if (m_cnt != M - 1) m_cnt++;
`else
            w = (m_cnt == M - 1);
            m_cnt = (m_cnt + 1) % M;
`endif
        end else if (en) begin
`ifdef JK_COUNTER_SATURATE_EN
            if (m_cnt != 0) m_cnt--;
`else
            w = (m_cnt == 0);
            m_cnt = (m_cnt == 0) ? M - 1 : m_cnt - 1;
`endif
        end
        x.cnt  = W'(m_cnt);
        x.wrap = w;
        x.tc   = up ? (m_cnt == M - 1) : (m_cnt == 0);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_neg = 1'b0;
        #1;
        checks++;
        if (count_out !== 4'h0 || count_out_neg !== 4'hF || wrap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: got cnt=%h neg=%h wrap=%b, want 0/F/0", count_out, count_out_neg, wrap_pulse);
        end
        m_cnt = 0;
        @(posedge clk);
        #1 reset_neg = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'd7);
        e = sb.pop_front();
        checks++;
        if (count_out !== e.cnt || count_out_neg !== ~e.cnt || wrap_pulse !== e.wrap || terminal_count !== e.tc) begin
            failures++;
            $display("FAIL reset_load7: got cnt=%0d neg=%h wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                     count_out, count_out_neg, wrap_pulse, terminal_count, e.cnt, e.wrap, e.tc);
        end
        count_enable = 1'b1;
        #2 reset_neg = 1'b0;
        #1;
        checks++;
        if (count_out !== 4'h0 || count_out_neg !== 4'hF || wrap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got cnt=%h neg=%h wrap=%b, want 0/F/0", count_out, count_out_neg, wrap_pulse);
        end
        m_cnt = 0;
        @(posedge clk);
        #1;
        checks++;
        if (count_out !== 4'h0 || count_out_neg !== 4'hF || wrap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got cnt=%h neg=%h wrap=%b, want 0/F/0", count_out, count_out_neg, wrap_pulse);
        end
        count_enable = 1'b0;
        reset_neg = 1'b1;
    endtask

    task automatic test_up_wrap();
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd0);
            e = sb.pop_front();
            checks++;
            if (count_out !== e.cnt || count_out_neg !== ~e.cnt || wrap_pulse !== e.wrap || terminal_count !== e.tc) begin
                failures++;
                $display("FAIL up_wrap step %0d: got cnt=%0d neg=%h wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                         i, count_out, count_out_neg, wrap_pulse, terminal_count, e.cnt, e.wrap, e.tc);
            end
        end
    endtask

    task automatic test_down_wrap();
        drive(1'b0, 1'b0, 1'b1, 4'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b1, 1'b0, 1'b0, 4'd0);
            e = sb.pop_front();
            checks++;
            if (count_out !== e.cnt || count_out_neg !== ~e.cnt || wrap_pulse !== e.wrap || terminal_count !== e.tc) begin
                failures++;
                $display("FAIL down_wrap step %0d: got cnt=%0d neg=%h wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                         i, count_out, count_out_neg, wrap_pulse, terminal_count, e.cnt, e.wrap, e.tc);
            end
        end
    endtask

    task automatic test_load_clamp();
        drive(1'b1, 1'b1, 1'b1, 4'd12);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b0, 1'b1, 1'b0, 4'd0);
            e = sb.pop_front();
            checks++;
            if (count_out !== e.cnt || count_out_neg !== ~e.cnt || wrap_pulse !== e.wrap || terminal_count !== e.tc) begin
                failures++;
                $display("FAIL load_clamp step %0d: got cnt=%0d neg=%h wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                         i, count_out, count_out_neg, wrap_pulse, terminal_count, e.cnt, e.wrap, e.tc);
            end
        end
    endtask

    task automatic test_dir_flip();
        count_up = 1'b1;
        #1;
        checks++;
        if (terminal_count !== (m_cnt == M - 1)) begin
            failures++;
            $display("FAIL flip_tc_up: got tc=%b, want %b", terminal_count, m_cnt == M - 1);
        end
        count_up = 1'b0;
        #1;
        checks++;
        if (terminal_count !== (m_cnt == 0)) begin
            failures++;
            $display("FAIL flip_tc_down: got tc=%b, want %b", terminal_count, m_cnt == 0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, i[0], 1'b0, 4'd0);
            e = sb.pop_front();
            checks++;
            if (count_out !== e.cnt || count_out_neg !== ~e.cnt || wrap_pulse !== e.wrap || terminal_count !== e.tc) begin
                failures++;
                $display("FAIL dir_flip step %0d: got cnt=%0d neg=%h wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                         i, count_out, count_out_neg, wrap_pulse, terminal_count, e.cnt, e.wrap, e.tc);
            end
        end
    endtask

    task automatic test_saturate();
        drive(1'b0, 1'b1, 1'b1, 4'd8);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                drive(1'b0, 1'b0, 1'b1, 4'd1);
                void'(sb.pop_front());
            end
            drive(1'b1, i < 4, 1'b0, 4'd0);
            e = sb.pop_front();
            checks++;
            if (count_out !== e.cnt || count_out_neg !== ~e.cnt || wrap_pulse !== e.wrap || terminal_count !== e.tc) begin
                failures++;
                $display("FAIL saturate step %0d: got cnt=%0d neg=%h wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                         i, count_out, count_out_neg, wrap_pulse, terminal_count, e.cnt, e.wrap, e.tc);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            e = sb.pop_front();
            checks++;
            if (count_out !== e.cnt || count_out_neg !== ~e.cnt || wrap_pulse !== e.wrap || terminal_count !== e.tc) begin
                failures++;
                $display("FAIL random step %0d: got cnt=%0d neg=%h wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                         i, count_out, count_out_neg, wrap_pulse, terminal_count, e.cnt, e.wrap, e.tc);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef JK_COUNTER_SATURATE_EN
        test_saturate();
`else
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_dir_flip();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
